// File: rtl/hatch_ctrl.sv
// Incubation sequencer: debounced start/abort key, staged incubation timer, chick animation loop.
// Define HATCH_TEMP_HOLD_EN to enable the temperature HOLD state and the temp alarm output.
module hatch_ctrl #(
    parameter int unsigned STAGE_MS = 1000,
    parameter int unsigned ANIM_MS  = 250,
    parameter int unsigned DB_MS    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       temp_bad,
    output logic [3:0] num,
    output logic       st,
    output logic       temp,
    output logic       done
);

    localparam int unsigned MS_W = (STAGE_MS > 1) ? $clog2(STAGE_MS) : 1;
    localparam int unsigned AN_W = (ANIM_MS  > 1) ? $clog2(ANIM_MS)  : 1;
    localparam int unsigned DB_W = (DB_MS    > 1) ? $clog2(DB_MS)    : 1;

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(STAGE_MS - 1);
    localparam logic [AN_W-1:0] AN_LAST = AN_W'(ANIM_MS - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INCUBATE,
`ifdef HATCH_TEMP_HOLD_EN
        HOLD,
`endif
        HATCHED
    } state_e;

    state_e          state_q;
    logic [3:0]      num_q;
    logic [MS_W-1:0] ms_cnt_q;
    logic [AN_W-1:0] anim_cnt_q;
    logic            st_q;
    logic            done_q;

    logic [1:0]      key_sync_q;
    logic            key_s;
    logic            key_acc_q, key_acc_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;

    assign key_s = key_sync_q[1];

    // Accepted level flips only after key_s has disagreed with it for DB_MS straight cycles.
    always_comb begin
        key_acc_d = key_acc_q;
        db_cnt_d  = '0;
        press_d   = 1'b0;
        if (key_s != key_acc_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_acc_d = key_s;
                press_d   = key_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sync_q <= '0;
            key_acc_q  <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            key_sync_q <= {key_sync_q[0], key_start};
            key_acc_q  <= key_acc_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

`ifdef HATCH_TEMP_HOLD_EN
    logic [1:0] temp_sync_q;
    logic       temp_s;
    logic       temp_q;

    assign temp_s = temp_sync_q[1];
    assign temp   = temp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temp_sync_q <= '0;
            temp_q      <= 1'b0;
        end else begin
            temp_sync_q <= {temp_sync_q[0], temp_bad};
            temp_q      <= temp_s;
        end
    end
`else
    logic unused_temp_bad;
    assign unused_temp_bad = temp_bad;
    assign temp            = 1'b0;
`endif

    // Abort and illegal-stage recovery share one path back to IDLE ahead of every other event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            num_q      <= '0;
            ms_cnt_q   <= '0;
            anim_cnt_q <= '0;
            st_q       <= 1'b0;
            done_q     <= 1'b0;
        end else if (state_q != IDLE && (press_q || num_q > 4'd11)) begin
            state_q    <= IDLE;
            num_q      <= '0;
            ms_cnt_q   <= '0;
            anim_cnt_q <= '0;
            st_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    num_q      <= '0;
                    ms_cnt_q   <= '0;
                    anim_cnt_q <= '0;
                    done_q     <= 1'b0;
                    if (press_q) begin
                        state_q <= INCUBATE;
                        st_q    <= 1'b1;
                    end
                end
                INCUBATE: begin
`ifdef HATCH_TEMP_HOLD_EN
                    if (temp_s) begin
                        state_q <= HOLD;
                    end else
`endif
                    if (ms_cnt_q == MS_LAST) begin
                        ms_cnt_q <= '0;
                        if (num_q == 4'd7) begin
                            num_q   <= 4'd8;
                            state_q <= HATCHED;
                            done_q  <= 1'b1;
                        end else begin
                            num_q <= num_q + 4'd1;
                        end
                    end else begin
                        ms_cnt_q <= ms_cnt_q + MS_W'(1);
                    end
                end
`ifdef HATCH_TEMP_HOLD_EN
                HOLD: begin
                    if (!temp_s) begin
                        state_q <= INCUBATE;
                    end
                end
`endif
                HATCHED: begin
                    if (anim_cnt_q == AN_LAST) begin
                        anim_cnt_q <= '0;
                        num_q      <= (num_q == 4'd11) ? 4'd8 : num_q + 4'd1;
                    end else begin
                        anim_cnt_q <= anim_cnt_q + AN_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    num_q      <= '0;
                    ms_cnt_q   <= '0;
                    anim_cnt_q <= '0;
                    st_q       <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign num  = num_q;
    assign st   = st_q;
    assign done = done_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// Scoreboard bench for hatch_ctrl with STAGE_MS=4, ANIM_MS=2, DB_MS=3.
// Expected outputs are queued per cycle by the stimulus and checked by an independent monitor.
module tb_hatch_ctrl;

`ifdef HATCH_TEMP_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_start = 1'b0;
    logic       temp_bad = 1'b0;
    logic [3:0] num;
    logic       st;
    logic       temp;
    logic       done;

    hatch_ctrl #(
        .STAGE_MS(4),
        .ANIM_MS (2),
        .DB_MS   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_start(key_start),
        .temp_bad (temp_bad),
        .num      (num),
        .st       (st),
        .temp     (temp),
        .done     (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int unsigned cyc;
        logic [3:0]  num;
        logic        st;
        logic        temp;
        logic        done;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string nm, input int unsigned c, input logic [3:0] n,
                            input logic s, input logic t, input logic d);
        exp_t e;
        e.name = nm; e.cyc = c; e.num = n; e.st = s; e.temp = t; e.done = d;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d not reached (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (num !== mon_e.num || st !== mon_e.st || temp !== mon_e.temp || done !== mon_e.done) begin
                errors++;
                $display("FAIL %s @%0d: got num=%0d st=%b temp=%b done=%b, want num=%0d st=%b temp=%b done=%b",
                         mon_e.name, cyc, num, st, temp, done, mon_e.num, mon_e.st, mon_e.temp, mon_e.done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    int unsigned n0;

    initial begin
        // Reset state and quiet idle after release
        tick(3);
        push_exp("reset_vals", cyc, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        rst = 1'b1;
        push_exp("post_reset_idle1", cyc + 1, 4'd0, 1'b0, 1'b0, 1'b0);
        push_exp("post_reset_idle5", cyc + 5, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(8);

        // Bouncing key never produces a press
        n0 = cyc;
        push_exp("bounce_10", n0 + 10, 4'd0, 1'b0, 1'b0, 1'b0);
        push_exp("bounce_20", n0 + 20, 4'd0, 1'b0, 1'b0, 1'b0);
        push_exp("bounce_35", n0 + 35, 4'd0, 1'b0, 1'b0, 1'b0);
        push_exp("bounce_44", n0 + 44, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            key_start = 1'b1;
            tick((i % 2 == 0) ? 1 : 2);
            key_start = 1'b0;
            tick(2);
        end
        tick(9);

        // Full run, then abort on a frame timeout in HATCHED
        n0 = cyc;
        temp_bad  = HOLD_EN ? 1'b0 : 1'b1;
        key_start = 1'b1;
        push_exp("st_before_press", n0 + 5, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            push_exp("stage_first", n0 + 6 + 4 * k, 4'(k), 1'b1, 1'b0, 1'b0);
            push_exp("stage_last",  n0 + 9 + 4 * k, 4'(k), 1'b1, 1'b0, 1'b0);
        end
        push_exp("hatched",  n0 + 38, 4'd8,  1'b1, 1'b0, 1'b1);
        push_exp("frame9",   n0 + 40, 4'd9,  1'b1, 1'b0, 1'b1);
        push_exp("frame10",  n0 + 42, 4'd10, 1'b1, 1'b0, 1'b1);
        push_exp("frame11",  n0 + 44, 4'd11, 1'b1, 1'b0, 1'b1);
        push_exp("frame8",   n0 + 46, 4'd8,  1'b1, 1'b0, 1'b1);
        tick(6);
        key_start = 1'b0;
        tick(36);
        key_start = 1'b1;
        push_exp("pre_abort_hatch", n0 + 47, 4'd8, 1'b1, 1'b0, 1'b1);
        push_exp("abort_hatch",     n0 + 48, 4'd0, 1'b0, 1'b0, 1'b0);
        push_exp("idle_after_hatch", n0 + 56, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(6);
        key_start = 1'b0;
        tick(10);
        temp_bad = 1'b0;
        tick(5);

`ifdef HATCH_TEMP_HOLD_EN
        // Temperature hold at num=3, ms_cnt=1; then abort in HOLD at a pending stage timeout
        n0 = cyc;
        key_start = 1'b1;
        push_exp("hold_pre",      n0 + 19, 4'd3, 1'b1, 1'b0, 1'b0);
        push_exp("hold_enter",    n0 + 20, 4'd3, 1'b1, 1'b1, 1'b0);
        push_exp("hold_mid",      n0 + 29, 4'd3, 1'b1, 1'b1, 1'b0);
        push_exp("hold_exit",     n0 + 30, 4'd3, 1'b1, 1'b0, 1'b0);
        push_exp("resume_2",      n0 + 32, 4'd3, 1'b1, 1'b0, 1'b0);
        push_exp("resume_step",   n0 + 33, 4'd4, 1'b1, 1'b0, 1'b0);
        push_exp("pre_hold2",     n0 + 36, 4'd4, 1'b1, 1'b0, 1'b0);
        push_exp("hold2_no_inc",  n0 + 37, 4'd4, 1'b1, 1'b1, 1'b0);
        push_exp("hold2_wait",    n0 + 39, 4'd4, 1'b1, 1'b1, 1'b0);
        push_exp("abort_hold",    n0 + 40, 4'd0, 1'b0, 1'b1, 1'b0);
        push_exp("idle_temp_clr", n0 + 50, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(6);
        key_start = 1'b0;
        tick(11);
        temp_bad = 1'b1;
        tick(10);
        temp_bad = 1'b0;
        tick(7);
        temp_bad  = 1'b1;
        key_start = 1'b1;
        tick(6);
        key_start = 1'b0;
        tick(5);
        temp_bad = 1'b0;
        tick(10);
`endif

        // Asynchronous reset mid-run, then stays idle
        n0 = cyc;
        key_start = 1'b1;
        if (HOLD_EN) push_exp("run_before_rst", n0 + 14, 4'd1, 1'b1, 1'b1, 1'b0);
        else         push_exp("run_before_rst", n0 + 14, 4'd2, 1'b1, 1'b0, 1'b0);
        tick(6);
        key_start = 1'b0;
        tick(3);
        temp_bad = 1'b1;
        tick(6);
        rst      = 1'b0;
        temp_bad = 1'b0;
        push_exp("async_rst",    cyc,     4'd0, 1'b0, 1'b0, 1'b0);
        push_exp("rst_held",     cyc + 2, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(3);
        rst = 1'b1;
        push_exp("rst_release8", cyc + 8, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(10);

        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked, cycle %0d", mon_e.name, mon_e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
